// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM type and default parameters for the data memory controller
package mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_WAIT   = 2;
  localparam int CNT_W      = 4;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus between a requester and data_mem_ctrl
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     rdata;
  logic                  ready;
  logic                  busy;
  logic                  err;

  modport master (output req, we, addr, wdata, be, input rdata, ready, busy, err);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, busy, err);
endinterface

// File: rtl/mem_array.sv
// rtl/mem_array.sv - byte-enabled word storage with a registered read port and a combinational debug port
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_W/8-1:0]        wr_be,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic                       rd_zero,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  input  logic [$clog2(DEPTH)-1:0]   dbg_idx,
  output logic [DATA_W-1:0]          dbg_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  // Storage has no reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  generate
    if (DEPTH == (1 << $clog2(DEPTH))) begin : g_pow2
      assign rd_word  = mem_q[rd_idx];
      assign dbg_data = mem_q[dbg_idx];
    end else begin : g_npow2
      assign rd_word  = (int'(rd_idx) < DEPTH) ? mem_q[rd_idx] : '0;
      assign dbg_data = (int'(dbg_idx) < DEPTH) ? mem_q[dbg_idx] : '0;
    end
  endgenerate

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_zero ? '0 : rd_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - wait-stated data memory controller: IDLE/WAIT/RESP FSM, range checks, completion pulse
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 32,
  parameter int WAIT   = DEF_WAIT
) (
  input  logic                      clk,
  input  logic                      reset,
  data_mem_ctrl_if.slave            bus,
  input  logic [$clog2(DEPTH)-1:0]  dbg_idx,
  output logic [DATA_W-1:0]         dbg_data
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              rej_q, rej_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;

  logic              req_rej, acc_we, acc_rej, rd_en, wr_en;
  logic [IW-1:0]     req_idx, acc_idx;

  function automatic logic rejected(input logic [ADDR_W-1:0] a);
    return ((a & ADDR_W'(NB - 1)) != '0) || ((a >> OB) >= ADDR_W'(DEPTH));
  endfunction

  assign req_rej = rejected(bus.addr);
  assign req_idx = IW'(bus.addr >> OB);

  // With WAIT=0 the read is captured on the sampling edge itself, so take the live request fields.
  assign acc_we  = (state_q == ST_IDLE) ? bus.we  : we_q;
  assign acc_rej = (state_q == ST_IDLE) ? req_rej : rej_q;
  assign acc_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      rej_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      rej_q   <= rej_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    rej_d   = rej_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          rej_d   = req_rej;
          idx_d   = req_idx;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          cnt_d   = CNT_W'(WAIT);
          state_d = (WAIT == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is captured on the edge entering RESP so it is valid alongside ready;
  // the write commits on the edge leaving RESP so a reset during RESP drops it.
  always_comb begin
    bus.busy  = (state_q != ST_IDLE);
    bus.ready = (state_q == ST_RESP);
    bus.err   = (state_q == ST_RESP) && rej_q;
    rd_en     = (state_d == ST_RESP) && (state_q != ST_RESP) && (!acc_we || acc_rej);
    wr_en     = (state_q == ST_RESP) && we_q && !rej_q;
  end

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_idx   (idx_q),
    .wr_be    (be_q),
    .wr_data  (wdata_q),
    .rd_en    (rd_en),
    .rd_zero  (acc_rej),
    .rd_idx   (acc_idx),
    .rd_data  (bus.rdata),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - scoreboard bench for data_mem_ctrl over three parameter sets
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) if_b ();
  data_mem_ctrl_if #(.DATA_W(64), .ADDR_W(32)) if_c ();

  logic [5:0]  dbg_a, dbg_b;
  logic [3:0]  dbg_c;
  logic [31:0] dd_a, dd_b;
  logic [63:0] dd_c;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT(2)) u_a (
    .clk(clk), .reset(reset), .bus(if_a), .dbg_idx(dbg_a), .dbg_data(dd_a));
  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .WAIT(0)) u_b (
    .clk(clk), .reset(reset), .bus(if_b), .dbg_idx(dbg_b), .dbg_data(dd_b));
  data_mem_ctrl #(.DATA_W(64), .DEPTH(16), .ADDR_W(32), .WAIT(3)) u_c (
    .clk(clk), .reset(reset), .bus(if_c), .dbg_idx(dbg_c), .dbg_data(dd_c));

  typedef struct {
    int          inst;
    bit          err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] ref_mem [3][64];
  logic [63:0] last_rd [3];
  int checks = 0;
  int errors = 0;

  function automatic int nb_of(input int i);
    return (i == 2) ? 8 : 4;
  endfunction
  function automatic int depth_of(input int i);
    return (i == 2) ? 16 : 64;
  endfunction
  function automatic int wait_of(input int i);
    case (i)
      0: return 2;
      1: return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0: return if_a.busy;
      1: return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction
  function automatic logic ready_of(input int i);
    case (i)
      0: return if_a.ready;
      1: return if_b.ready;
      default: return if_c.ready;
    endcase
  endfunction
  function automatic logic err_of(input int i);
    case (i)
      0: return if_a.err;
      1: return if_b.err;
      default: return if_c.err;
    endcase
  endfunction
  function automatic logic [63:0] rdata_of(input int i);
    case (i)
      0: return {32'd0, if_a.rdata};
      1: return {32'd0, if_b.rdata};
      default: return if_c.rdata;
    endcase
  endfunction
  function automatic logic [63:0] dbg_of(input int i);
    case (i)
      0: return {32'd0, dd_a};
      1: return {32'd0, dd_b};
      default: return dd_c;
    endcase
  endfunction

  function automatic int find_exp(input int i);
    foreach (sb[k]) if (sb[k].inst == i) return k;
    return -1;
  endfunction
  function automatic int pending(input int i);
    int n = 0;
    foreach (sb[k]) if (sb[k].inst == i) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int i, input bit r, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] b);
    case (i)
      0: begin if_a.req = r; if_a.we = w; if_a.addr = a; if_a.wdata = d[31:0]; if_a.be = b[3:0]; end
      1: begin if_b.req = r; if_b.we = w; if_b.addr = a; if_b.wdata = d[31:0]; if_b.be = b[3:0]; end
      default: begin if_c.req = r; if_c.we = w; if_c.addr = a; if_c.wdata = d; if_c.be = b; end
    endcase
  endtask

  task automatic set_dbg(input int i, input int idx);
    case (i)
      0: dbg_a = 6'(idx);
      1: dbg_b = 6'(idx);
      default: dbg_c = 4'(idx);
    endcase
  endtask

  // Reference model: word-addressed array, byte-merge writes, rejection by alignment/range arithmetic.
  task automatic model(input int i, input bit w, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] b, input int at);
    exp_t e;
    int nb;
    int idx;
    nb     = nb_of(i);
    e.inst = i;
    e.cyc  = at + wait_of(i);
    e.err  = ((a % nb) != 0) || ((a / nb) >= depth_of(i));
    if (e.err) begin
      last_rd[i] = '0;
    end else begin
      idx = int'(a / nb);
      if (w) begin
        for (int k = 0; k < nb; k++)
          if (b[k]) ref_mem[i][idx][8*k +: 8] = d[8*k +: 8];
      end else begin
        last_rd[i] = ref_mem[i][idx];
      end
    end
    e.rdata = last_rd[i];
    sb.push_back(e);
  endtask

  task automatic issue_now(input int i, input bit w, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] b);
    int n = 0;
    drive(i, 1'b1, w, a, d, b);
    @(posedge clk);
    #1;
    model(i, w, a, d, b, cyc);
    drive(i, 1'b0, 1'b0, '0, '0, '0);
    while (pending(i) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("resp_timeout[%0d]", i), 64'(pending(i)), 64'd0);
    @(negedge clk);
  endtask

  task automatic access(input int i, input bit w, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (busy_of(i) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_timeout[%0d]", i), 64'(busy_of(i)), 64'd0);
    issue_now(i, w, a, d, b);
  endtask

  task automatic dbg_chk(input int i, input int idx);
    set_dbg(i, idx);
    #1;
    chk($sformatf("dbg[%0d][%0d]", i, idx), dbg_of(i), ref_mem[i][idx]);
  endtask

  task automatic rand_acc(input int i);
    int nb, dp, r;
    logic [31:0] a;
    nb = nb_of(i);
    dp = depth_of(i);
    r  = int'($urandom_range(0, 9));
    if (r < 7)      a = 32'(nb * int'($urandom_range(0, dp - 1)));
    else if (r < 9) a = 32'(nb * int'($urandom_range(0, dp - 1)) + int'($urandom_range(1, nb - 1)));
    else            a = 32'(nb * dp) + 32'($urandom_range(0, 255));
    access(i, 1'($urandom_range(0, 1)), a, {$urandom(), $urandom()}, 8'($urandom()));
    dbg_chk(i, int'($urandom_range(0, dp - 1)));
  endtask

  exp_t m_e;
  int   m_k;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("err_gate[%0d]", i), 64'(err_of(i) & ~ready_of(i)), 64'd0);
      if (ready_of(i)) begin
        m_k = find_exp(i);
        if (m_k < 0) begin
          chk($sformatf("unexpected_ready[%0d]", i), 64'(ready_of(i)), 64'd0);
        end else begin
          m_e = sb[m_k];
          sb.delete(m_k);
          chk($sformatf("err[%0d]", i), 64'(err_of(i)), 64'(m_e.err));
          chk($sformatf("rdata[%0d]", i), rdata_of(i), m_e.rdata);
          chk($sformatf("latency[%0d]", i), 64'(cyc), 64'(m_e.cyc));
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = '0;
      for (int k = 0; k < 64; k++) ref_mem[i][k] = '0;
      drive(i, 1'b0, 1'b0, '0, '0, '0);
      set_dbg(i, 0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_busy[%0d]", i),  64'(busy_of(i)),  64'd0);
      chk($sformatf("rst_ready[%0d]", i), 64'(ready_of(i)), 64'd0);
      chk($sformatf("rst_err[%0d]", i),   64'(err_of(i)),   64'd0);
      chk($sformatf("rst_rdata[%0d]", i), rdata_of(i),      64'd0);
    end
    reset = 1'b0;

    for (int k = 0; k < 64; k++) access(0, 1'b1, 32'(4 * k), {32'd0, $urandom()}, 8'hFF);
    for (int k = 0; k < 16; k++) access(2, 1'b1, 32'(8 * k), {$urandom(), $urandom()}, 8'hFF);
    access(1, 1'b1, 32'h20, 64'hCAFEF00D, 8'h0F);

    access(0, 1'b1, 32'h10, 64'hDEADBEEF, 8'h0F);
    access(0, 1'b0, 32'h10, '0, '0);
    set_dbg(0, 4); #1;
    chk("dbg_beef", dbg_of(0), 64'hDEADBEEF);
    access(0, 1'b1, 32'h10, 64'h11223344, 8'b0101);
    access(0, 1'b0, 32'h10, '0, '0);
    chk("merge_rdata", rdata_of(0), 64'hDE22BE44);
    access(0, 1'b0, 32'h13, '0, '0);
    access(0, 1'b0, 32'h100, '0, '0);
    chk("rej_rdata", rdata_of(0), 64'd0);
    set_dbg(0, 4); #1;
    chk("rej_mem_intact", dbg_of(0), 64'hDE22BE44);

    access(2, 1'b1, 32'h78, 64'h0123456789ABCDEF, 8'hFF);
    access(2, 1'b0, 32'h78, '0, '0);
    chk("wide_rdata", rdata_of(2), 64'h0123456789ABCDEF);
    access(2, 1'b0, 32'h80, '0, '0);

    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h20, '0, '0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (c % 2 == 0) model(1, 1'b0, 32'h20, '0, '0, cyc);
      if (c == 5) drive(1, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk($sformatf("b2b_busy%0d", c),  64'(busy_of(1)),  64'(c % 2 == 0));
      chk($sformatf("b2b_ready%0d", c), 64'(ready_of(1)), 64'(c % 2 == 0));
    end

    for (int n = 0; n < 30; n++) begin
      rand_acc(0);
      rand_acc(2);
    end

    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h8, 64'h55AA55AA, 8'h0F);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_of(0)), 64'd0);
    chk("abort_ready", 64'(ready_of(0)), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_rdata[%0d]", i), rdata_of(i), 64'd0);
      last_rd[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue_now(0, 1'b0, 32'h8, '0, '0);
    dbg_chk(0, 2);

    repeat (5) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, which is the data word width in bits (multiple of 8, at least 16).
REQ-002 The block SHALL have parameter DEPTH, default 64, which is the number of words held.
REQ-003 The block SHALL have parameter ADDR_W, default 32, which is the byte address width.
REQ-004 The block SHALL have parameter WAIT, default 2, which is the number of wait cycles per access (0..15).
REQ-005 Port clk SHALL be an input, 1 bit wide: the single system clock; all state changes on its rising edge.
REQ-006 Port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-007 Port req SHALL be an input, 1 bit wide: access request, sampled only in IDLE.
REQ-008 Port we SHALL be an input, 1 bit wide: 1 = write, 0 = read.
REQ-009 Port addr SHALL be an input, ADDR_W bits wide: byte address.
REQ-010 Port wdata SHALL be an input, DATA_W bits wide: write data.
REQ-011 Port be SHALL be an input, DATA_W/8 bits wide: byte enables for writes.
REQ-012 Port rdata SHALL be an output, DATA_W bits wide: registered read data.
REQ-013 Port ready SHALL be an output, 1 bit wide: one-cycle completion pulse.
REQ-014 Port busy SHALL be an output, 1 bit wide: high while an access is in progress.
REQ-015 Port err SHALL be an output, 1 bit wide: high together with ready when the access was rejected.
REQ-016 Port dbg_idx SHALL be an input, $clog2(DEPTH) bits wide: debug word index.
REQ-017 Port dbg_data SHALL be an output, DATA_W bits wide: combinational contents of word dbg_idx.

Function
REQ-018 Byte-offset bits SHALL be OB = $clog2(DATA_W/8); word index SHALL be addr[ADDR_W-1:OB].
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-020 In IDLE with req=1, the block SHALL latch we, addr, wdata and be, load the wait counter with WAIT, and go to WAIT; if WAIT=0 it SHALL go directly to RESP.
REQ-021 In WAIT the counter SHALL decrement each cycle, and the block SHALL go to RESP in the cycle after the counter reaches 1.
REQ-022 In RESP the block SHALL assert ready for exactly one cycle, perform the access, and return to IDLE.
REQ-023 ready SHALL be asserted in cycle WAIT+1 after the req sampling edge.
REQ-024 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-025 req SHALL be ignored while busy=1; a req held high through RESP SHALL start a new access at the first IDLE edge (back-to-back throughput: one access per WAIT+2 cycles).
REQ-026 A write SHALL update only the bytes whose be bit is 1; be=0 SHALL complete normally without changing memory.
REQ-027 A read SHALL load rdata with the whole word in RESP; rdata SHALL hold its value until the next successful read.
REQ-028 An access SHALL be rejected when addr[OB-1:0]≠0 or word index ≥ DEPTH.
REQ-029 A rejected access SHALL assert err with ready, SHALL NOT write memory, and SHALL set rdata to 0.
REQ-030 err SHALL be 0 whenever ready=0.
REQ-031 dbg_data SHALL reflect the memory contents including a write committed at the previous edge; dbg_idx ≥ DEPTH SHALL return 0.

Reset
REQ-032 On reset assertion, the block SHALL immediately set state to IDLE, counter to 0, and rdata, ready, busy and err to 0.
REQ-033 Reset SHALL NOT clear memory contents.
REQ-034 Reset during WAIT or RESP SHALL abort the access with no write and no ready pulse.
REQ-035 The first req SHALL be sampled on the first rising edge after reset deasserts.

Structure
REQ-036 A shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default DATA_W, DEPTH and WAIT constants.
REQ-037 Storage SHALL be a sub-module mem_array (byte-enabled write port, one synchronous read port, one combinational debug port); the FSM, counter and checks SHALL live in data_mem_ctrl.

Verification
REQ-038 Bench SHALL test: WAIT=2, write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> ready 3 cycles after each req, rdata=0xDEADBEEF, dbg_data(idx 4)=0xDEADBEEF.
REQ-039 Bench SHALL test: word at 0x10 = 0xDEADBEEF, write 0x11223344 with be=4'b0101 -> read returns 0xDE22BE44.
REQ-040 Bench SHALL test: read 0x13 (misaligned) and read 0x100 with DEPTH=64 -> ready+err, rdata=0, memory unchanged.
REQ-041 Bench SHALL test: WAIT=0, req held high for 6 cycles of reads -> ready pulses on every second cycle, busy toggling.
REQ-042 Bench SHALL test: reset asserted during WAIT of a write to 0x8 -> busy=0 immediately, no ready, word 2 unchanged.
REQ-043 Bench SHALL test: DATA_W=64, DEPTH=16 -> write 0x0123456789ABCDEF to 0x78, read back exact, and access to 0x80 -> err.
